// File: rtl/ines_rom_parser.sv
// iNES ROM parser: validates the 16-byte header, skips an optional trainer and
// steers PRG/CHR payload bytes to SDRAM as single-cycle write strobes.
module ines_rom_parser #(
  parameter int                ADDR_W        = 22,
  parameter logic [ADDR_W-1:0] PRG_BASE      = ADDR_W'(22'h000000),
  parameter logic [ADDR_W-1:0] CHR_BASE      = ADDR_W'(22'h200000),
  parameter int                MAX_PRG_BANKS = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        indata,
  input  logic              indata_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_write,
  output logic [7:0]        prg_banks,
  output logic [7:0]        chr_banks,
  output logic [7:0]        mapper,
  output logic              mirror_v,
  output logic              battery,
  output logic              four_screen,
  output logic              chr_ram,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_HEADER, S_TRAINER, S_PRG, S_CHR, S_DONE, S_ERROR
  } state_t;

  localparam logic [8:0] LP_MAX_PRG = 9'(MAX_PRG_BANKS);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [7:0]        r_hdr4, r_hdr5, r_hdr6;
  logic [3:0]        r_hdr7_hi;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_mem_write;
  logic [7:0]        r_prg_banks, r_chr_banks, r_mapper;
  logic              r_mirror_v, r_battery, r_four_screen, r_chr_ram;
  logic              r_done, r_error;

  logic [7:0]        w_magic;
  logic              w_magic_bad;
  logic              w_counting;
  logic [ADDR_W-1:0] w_prg_limit, w_chr_limit;
  logic              w_prg_last, w_chr_last, w_hdr_bad;

  always_comb begin
    w_magic = 8'h1A;
    case (r_cnt[1:0])
      2'd0:    w_magic = 8'h4E;
      2'd1:    w_magic = 8'h45;
      2'd2:    w_magic = 8'h53;
      default: w_magic = 8'h1A;
    endcase
  end

  assign w_magic_bad = (r_cnt < ADDR_W'(4)) && (indata != w_magic);
  assign w_hdr_bad   = (r_hdr4 == 8'd0) || ({1'b0, r_hdr4} > LP_MAX_PRG);
  assign w_prg_limit = ADDR_W'({r_prg_banks, 14'b0});
  assign w_chr_limit = ADDR_W'({r_chr_banks, 13'b0});
  assign w_prg_last  = (r_cnt == w_prg_limit - ADDR_W'(1));
  assign w_chr_last  = (r_cnt == w_chr_limit - ADDR_W'(1));
  assign w_counting  = (r_state != S_DONE) && (r_state != S_ERROR);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_HEADER;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_HEADER: begin
        if (indata_valid) begin
          if (w_magic_bad)                 w_state_next = S_ERROR;
          else if (r_cnt == ADDR_W'(15)) begin
            if (w_hdr_bad)                 w_state_next = S_ERROR;
            else if (r_hdr6[2])            w_state_next = S_TRAINER;
            else                           w_state_next = S_PRG;
          end
        end
      end
      S_TRAINER: if (indata_valid && r_cnt == ADDR_W'(511)) w_state_next = S_PRG;
      S_PRG:     if (indata_valid && w_prg_last) w_state_next = r_chr_ram ? S_DONE : S_CHR;
      S_CHR:     if (indata_valid && w_chr_last) w_state_next = S_DONE;
      S_DONE:    w_state_next = S_DONE;
      S_ERROR:   w_state_next = S_ERROR;
      default:   w_state_next = S_HEADER;
    endcase
  end

  // done lags the final write pulse by one cycle so it only rises once the
  // last byte has actually been presented to the arbiter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt         <= '0;
      r_hdr4        <= '0;
      r_hdr5        <= '0;
      r_hdr6        <= '0;
      r_hdr7_hi     <= '0;
      r_mem_addr    <= '0;
      r_mem_data    <= '0;
      r_mem_write   <= 1'b0;
      r_prg_banks   <= '0;
      r_chr_banks   <= '0;
      r_mapper      <= '0;
      r_mirror_v    <= 1'b0;
      r_battery     <= 1'b0;
      r_four_screen <= 1'b0;
      r_chr_ram     <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      r_error     <= (w_state_next == S_ERROR);
      r_done      <= (r_state == S_DONE);
      if (w_state_next != r_state)        r_cnt <= '0;
      else if (indata_valid && w_counting) r_cnt <= r_cnt + ADDR_W'(1);
      if (indata_valid && r_state == S_HEADER) begin
        case (r_cnt[3:0])
          4'd4: r_hdr4    <= indata;
          4'd5: r_hdr5    <= indata;
          4'd6: r_hdr6    <= indata;
          4'd7: r_hdr7_hi <= indata[7:4];
          4'd15: begin
            r_prg_banks   <= r_hdr4;
            r_chr_banks   <= r_hdr5;
            r_mapper      <= {r_hdr7_hi, r_hdr6[7:4]};
            r_mirror_v    <= r_hdr6[0];
            r_battery     <= r_hdr6[1];
            r_four_screen <= r_hdr6[3];
            r_chr_ram     <= (r_hdr5 == 8'd0);
          end
          default: ;
        endcase
      end
      if (indata_valid && (r_state == S_PRG || r_state == S_CHR)) begin
        r_mem_write <= 1'b1;
        r_mem_addr  <= ((r_state == S_PRG) ? PRG_BASE : CHR_BASE) + r_cnt;
        r_mem_data  <= indata;
      end
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign mem_write   = r_mem_write;
  assign prg_banks   = r_prg_banks;
  assign chr_banks   = r_chr_banks;
  assign mapper      = r_mapper;
  assign mirror_v    = r_mirror_v;
  assign battery     = r_battery;
  assign four_screen = r_four_screen;
  assign chr_ram     = r_chr_ram;
  assign done        = r_done;
  assign error       = r_error;

endmodule

// File: tb/tb_ines_rom_parser.sv
// Self-checking bench for ines_rom_parser: header decode table plus directed
// multi-cycle load, trainer, error and mid-stream reset sequences.
module tb_ines_rom_parser;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  indata = 8'h00;
  logic        indata_valid = 1'b0;
  logic [21:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_write;
  logic [7:0]  prg_banks, chr_banks, mapper;
  logic        mirror_v, battery, four_screen, chr_ram, done, error;

  int numChecks = 0;
  int numFails  = 0;

  ines_rom_parser dut (
    .clk(clk), .resetn(resetn), .indata(indata), .indata_valid(indata_valid),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .prg_banks(prg_banks), .chr_banks(chr_banks), .mapper(mapper),
    .mirror_v(mirror_v), .battery(battery), .four_screen(four_screen),
    .chr_ram(chr_ram), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] hdr;
    logic         expErr;
    logic [7:0]   expPrg, expChr, expMapper;
    logic         expMv, expBat, expFs, expChrRam;
  } hdrVec_t;

  hdrVec_t vecs[8];

  // One clock: drive inputs, let the edge happen, sample 1 ns later.
  task automatic applyStimulus(input logic rstN, input logic v, input logic [7:0] d);
    resetn       = rstN;
    indata_valid = v;
    indata       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendHeader(input logic [127:0] h, output int writes);
    writes = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, h[127-8*i -: 8]);
      if (mem_write === 1'b1) writes++;
    end
  endtask

  // Streams n payload bytes (value = low address byte); counts every write
  // that deviates from the expected address/data/latency.
  task automatic streamPayload(input int n, input logic expWr, input logic [21:0] base,
                               input int gapEvery, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (gapEvery > 0 && (i % gapEvery) == gapEvery - 1) begin
        applyStimulus(1'b1, 1'b0, 8'hFF);
        if (mem_write !== 1'b0) bad++;
        if (expWr && i > 0 && mem_addr !== base + 22'(i - 1)) bad++;
      end
      applyStimulus(1'b1, 1'b1, 8'(i));
      if (mem_write !== expWr) bad++;
      else if (expWr && (mem_addr !== base + 22'(i) || mem_data !== 8'(i))) bad++;
      if (done !== 1'b0 || error !== 1'b0) bad++;
    end
  endtask

  initial begin
    int bad, writes;

    vecs[0] = '{128'h4E45531A_02010100_00000000_00000000, 1'b0, 8'h02, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{128'h4E45531A_01001B40_00000000_00000000, 1'b0, 8'h01, 8'h00, 8'h41, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{128'h4E45531A_800004F0_00000000_00000000, 1'b0, 8'h80, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{128'h4E45531A_0302A270_00000000_00000000, 1'b0, 8'h03, 8'h02, 8'h7A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{128'h4E45531A_00010000_00000000_00000000, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{128'h4E45531A_81010000_00000000_00000000, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{128'h4F45531A_01010000_00000000_00000000, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{128'h4E45531B_01010000_00000000_00000000, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    $display("[TB] reset state");
    doReset();
    checkOutput("rst0_write", 32'(mem_write), 32'h0);
    checkOutput("rst0_addrData", 32'({mem_addr, mem_data}), 32'h0);
    checkOutput("rst0_cfg", 32'({prg_banks, chr_banks, mapper}), 32'h0);
    checkOutput("rst0_flags", 32'({mirror_v, battery, four_screen, chr_ram, done, error}), 32'h0);

    $display("[TB] header decode table");
    for (int v = 0; v < 8; v++) begin
      doReset();
      sendHeader(vecs[v].hdr, writes);
      checkOutput($sformatf("hdr%0d_error", v), 32'(error), 32'(vecs[v].expErr));
      checkOutput($sformatf("hdr%0d_writes", v), 32'(writes), 32'h0);
      if (!vecs[v].expErr) begin
        checkOutput($sformatf("hdr%0d_banks", v), 32'({prg_banks, chr_banks}),
                    32'({vecs[v].expPrg, vecs[v].expChr}));
        checkOutput($sformatf("hdr%0d_mapper", v), 32'(mapper), 32'(vecs[v].expMapper));
        checkOutput($sformatf("hdr%0d_flags", v), 32'({mirror_v, battery, four_screen, chr_ram, done}),
                    32'({vecs[v].expMv, vecs[v].expBat, vecs[v].expFs, vecs[v].expChrRam, 1'b0}));
      end
    end

    $display("[TB] full PRG+CHR load");
    doReset();
    sendHeader(128'h4E45531A_02010100_00000000_00000000, writes);
    streamPayload(32768, 1'b1, 22'h000000, 0, bad);
    checkOutput("load_prgStream", 32'(bad), 32'h0);
    streamPayload(8192, 1'b1, 22'h200000, 0, bad);
    checkOutput("load_chrStream", 32'(bad), 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("load_doneAfterLastWrite", 32'({done, error, mem_write}), 32'b100);
    checkOutput("load_addrHold", 32'({mem_addr, mem_data}), 32'({22'h201FFF, 8'hFF}));
    checkOutput("load_cfg", 32'({mirror_v, mapper, chr_ram}), 32'({1'b1, 8'h00, 1'b0}));
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h5A);
      if (mem_write === 1'b1) writes++;
    end
    checkOutput("load_trailingWrites", 32'(writes), 32'h0);
    checkOutput("load_doneHolds", 32'(done), 32'h1);

    $display("[TB] trainer skip with idle gaps");
    doReset();
    sendHeader(128'h4E45531A_01000400_00000000_00000000, writes);
    streamPayload(512, 1'b0, 22'h000000, 0, bad);
    checkOutput("trn_skipStream", 32'(bad), 32'h0);
    streamPayload(16384, 1'b1, 22'h000000, 7, bad);
    checkOutput("trn_prgStream", 32'(bad), 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("trn_done", 32'({done, chr_ram, error}), 32'b110);
    applyStimulus(1'b1, 1'b1, 8'h11);
    checkOutput("trn_noChrWrite", 32'(mem_write), 32'h0);

    $display("[TB] bad magic");
    doReset();
    applyStimulus(1'b1, 1'b1, 8'h4E);
    applyStimulus(1'b1, 1'b1, 8'h45);
    checkOutput("net_errorEarly", 32'(error), 32'h0);
    applyStimulus(1'b1, 1'b1, 8'h54);
    checkOutput("net_errorAfterByte2", 32'(error), 32'h1);
    writes = 0;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i));
      if (mem_write === 1'b1) writes++;
    end
    checkOutput("net_writes", 32'(writes), 32'h0);
    checkOutput("net_flags", 32'({error, done}), 32'b10);

    $display("[TB] rejected PRG bank counts");
    for (int k = 0; k < 2; k++) begin
      logic [127:0] h;
      h = (k == 0) ? 128'h4E45531A_00010000_00000000_00000000
                   : 128'h4E45531A_81010000_00000000_00000000;
      doReset();
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, h[127-8*i -: 8]);
      checkOutput($sformatf("banks%0d_errorBefore15", k), 32'(error), 32'h0);
      applyStimulus(1'b1, 1'b1, h[7:0]);
      checkOutput($sformatf("banks%0d_errorAt15", k), 32'(error), 32'h1);
      writes = 0;
      for (int i = 0; i < 20; i++) begin
        applyStimulus(1'b1, 1'b1, 8'h77);
        if (mem_write === 1'b1) writes++;
      end
      checkOutput($sformatf("banks%0d_writes", k), 32'(writes), 32'h0);
    end

    $display("[TB] reset mid-stream, then reload");
    doReset();
    sendHeader(128'h4E45531A_01000100_00000000_00000000, writes);
    streamPayload(100, 1'b1, 22'h000000, 0, bad);
    checkOutput("mid_firstStream", 32'(bad), 32'h0);
    applyStimulus(1'b0, 1'b1, 8'hAA);
    checkOutput("mid_rstWrite", 32'(mem_write), 32'h0);
    checkOutput("mid_rstAddrData", 32'({mem_addr, mem_data}), 32'h0);
    checkOutput("mid_rstCfg", 32'({prg_banks, chr_banks, mapper}), 32'h0);
    checkOutput("mid_rstFlags", 32'({mirror_v, battery, four_screen, chr_ram, done, error}), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    sendHeader(128'h4E45531A_01001B40_00000000_00000000, writes);
    checkOutput("mid_mapper", 32'(mapper), 32'h41);
    checkOutput("mid_flags", 32'({mirror_v, battery, four_screen, error}), 32'b1110);
    streamPayload(16384, 1'b1, 22'h000000, 0, bad);
    checkOutput("mid_reloadStream", 32'(bad), 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("mid_done", 32'({done, error}), 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
